// File: rtl/id_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_pipe_pkg
// Shared constants and types for the RV32I decode stage (id_pipe / id_decode):
// opcode and funct3/funct7 encodings, reset polarity, enable levels, the zero
// word, and the decoded-control struct passed from id_decode to id_pipe.
// Optional feature macro (consumed in id_decode): ID_PIPE_RVM_EN.
// -----------------------------------------------------------------------------
package id_pipe_pkg;

  // Opcodes (inst[6:0])
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ALU funct3 (OP_R / OP_I)
  localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNC3_SLL     = 3'b001;
  localparam logic [2:0] FUNC3_SLT     = 3'b010;
  localparam logic [2:0] FUNC3_SLTU    = 3'b011;
  localparam logic [2:0] FUNC3_XOR     = 3'b100;
  localparam logic [2:0] FUNC3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNC3_OR      = 3'b110;
  localparam logic [2:0] FUNC3_AND     = 3'b111;

  // Load funct3
  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;

  // Store funct3
  localparam logic [2:0] FUNC3_SB = 3'b000;
  localparam logic [2:0] FUNC3_SH = 3'b001;
  localparam logic [2:0] FUNC3_SW = 3'b010;

  // Branch funct3
  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;

  // JALR funct3
  localparam logic [2:0] FUNC3_JALR = 3'b000;

  // funct7
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Reset level and enable encodings
  localparam logic        RstEnable    = 1'b0;
  localparam logic        ReadEnable   = 1'b1;
  localparam logic        ReadDisable  = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // Decoded controls for one instruction
  typedef struct packed {
    logic        re1;
    logic        re2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_pipe_decode.sv
// -----------------------------------------------------------------------------
// id_decode
// Purely combinational RV32I instruction decoder.
// Ports:
//   inst_i  [31:0]  instruction word
//   dec_o   dec_t   {re1, re2, we, waddr, imm (32-bit, sign-extended), illegal}
// An unrecognised encoding returns illegal=1 with every enable, waddr and imm
// at zero. waddr is zero whenever we is zero.
// Macro: ID_PIPE_RVM_EN - when defined, OP_R with funct7=0000001 (RV32M) is
// legal for every funct3; otherwise it is illegal.
// -----------------------------------------------------------------------------
module id_decode
  import id_pipe_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;
  logic        legal;
  dec_t        dec;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'h000};
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_sh = {27'h0, inst_i[24:20]};

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.re1 = ReadEnable;
        dec.re2 = ReadEnable;
        dec.we  = WriteEnable;
        unique case (funct7)
          FUNCT7_BASE:   legal = 1'b1;
          // SUB and SRA are the only alternate-encoded R-type ops
          FUNCT7_ALT:    legal = (funct3 == FUNC3_ADD_SUB) || (funct3 == FUNC3_SRL_SRA);
`ifdef ID_PIPE_RVM_EN
          FUNCT7_MULDIV: legal = 1'b1;
`else
          FUNCT7_MULDIV: legal = 1'b0;
`endif
          default:       legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec.re1 = ReadEnable;
        dec.we  = WriteEnable;
        if (funct3 == FUNC3_SLL) begin
          legal   = (funct7 == FUNCT7_BASE);
          dec.imm = imm_sh;
        end else if (funct3 == FUNC3_SRL_SRA) begin
          legal   = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          dec.imm = imm_sh;
        end else begin
          legal   = 1'b1;
          dec.imm = imm_i;
        end
      end
      OP_L: begin
        dec.re1 = ReadEnable;
        dec.we  = WriteEnable;
        dec.imm = imm_i;
        legal   = (funct3 == FUNC3_LB) || (funct3 == FUNC3_LH) || (funct3 == FUNC3_LW) ||
                  (funct3 == FUNC3_LBU) || (funct3 == FUNC3_LHU);
      end
      OP_S: begin
        dec.re1 = ReadEnable;
        dec.re2 = ReadEnable;
        dec.imm = imm_s;
        legal   = (funct3 == FUNC3_SB) || (funct3 == FUNC3_SH) || (funct3 == FUNC3_SW);
      end
      OP_B: begin
        dec.re1 = ReadEnable;
        dec.re2 = ReadEnable;
        dec.imm = imm_b;
        legal   = (funct3 == FUNC3_BEQ) || (funct3 == FUNC3_BNE) || (funct3 == FUNC3_BLT) ||
                  (funct3 == FUNC3_BGE) || (funct3 == FUNC3_BLTU) || (funct3 == FUNC3_BGEU);
      end
      OP_LUI, OP_AUIPC: begin
        dec.we  = WriteEnable;
        dec.imm = imm_u;
        legal   = 1'b1;
      end
      OP_JAL: begin
        dec.we  = WriteEnable;
        dec.imm = imm_j;
        legal   = 1'b1;
      end
      OP_JALR: begin
        dec.re1 = ReadEnable;
        dec.we  = WriteEnable;
        dec.imm = imm_i;
        legal   = (funct3 == FUNC3_JALR);
      end
      default: legal = 1'b0;
    endcase

    if (dec.we) begin
      dec.waddr = inst_i[11:7];
    end

    // Illegal encodings carry no side effects downstream
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/id_pipe.sv
// -----------------------------------------------------------------------------
// id_pipe
// Registered RV32I decode stage between IF/ID and execute.
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   in_valid/in_ready        instruction handshake from fetch
//   in_pc, in_inst           instruction address and word
//   flush                    kill held and incoming instruction
//   reg1/2_raddr             regfile read addresses (combinational from in_inst)
//   reg1/2_rdata             regfile read data (same cycle)
//   fwd_we/ld/waddr/wdata    NUM_FWD forwarding sources, index 0 = youngest
//   out_valid/out_ready      handshake to execute
//   out_pc, out_inst         registered copies of the accepted instruction
//   out_reg1/2, out_imm      resolved operands and sign-extended immediate
//   out_waddr, out_we        destination and write enable
//   out_illegal              instruction not recognised
//   stall_cnt                saturating count of hazard-stall cycles
// Macro: ID_PIPE_RVM_EN (see id_decode) enables RV32M decode.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on the consumer's state but never on the
// producer's valid.
// -----------------------------------------------------------------------------
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  input  logic                    flush,
  output logic [4:0]              reg1_raddr,
  output logic [4:0]              reg2_raddr,
  input  logic [XLEN-1:0]         reg1_rdata,
  input  logic [XLEN-1:0]         reg2_rdata,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_ld,
  input  logic [NUM_FWD*5-1:0]    fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_reg1,
  output logic [XLEN-1:0]         out_reg2,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_waddr,
  output logic                    out_we,
  output logic                    out_illegal,
  output logic [CNT_W-1:0]        stall_cnt
);

  dec_t            dec;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            haz1;
  logic            haz2;
  logic            hazard;
  logic            free;
  logic            accept;
  logic            stall_inc;

  logic            valid_q,   valid_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] reg1_q;
  logic [XLEN-1:0] reg2_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      waddr_q;
  logic            we_q;
  logic            illegal_q;

  id_decode u_decode (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  assign rs1        = in_inst[19:15];
  assign rs2        = in_inst[24:20];
  assign reg1_raddr = rs1;
  assign reg2_raddr = rs2;

  always_comb begin
    imm_ext       = {XLEN{dec.imm[31]}};
    imm_ext[31:0] = dec.imm;
  end

  // Operand resolution. Sources are scanned from oldest to youngest so the
  // lowest matching index is the last assignment and wins. The hazard flag
  // follows the same winner, so an older pending load shadowed by a younger
  // non-load write to the same register does not stall.
  always_comb begin
    op1  = '0;
    op2  = '0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (dec.re1 && (rs1 != 5'd0)) begin
      op1 = reg1_rdata;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_waddr[i*5 +: 5] == rs1)) begin
          op1  = fwd_wdata[i*XLEN +: XLEN];
          haz1 = fwd_ld[i];
        end
      end
    end
    if (dec.re2 && (rs2 != 5'd0)) begin
      op2 = reg2_rdata;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_waddr[i*5 +: 5] == rs2)) begin
          op2  = fwd_wdata[i*XLEN +: XLEN];
          haz2 = fwd_ld[i];
        end
      end
    end
  end

  assign hazard    = haz1 | haz2;
  assign free      = !valid_q | out_ready;
  // Gated by reset so fetch sees no ready while the stage is being cleared
  assign in_ready  = (rst != RstEnable) & free & !hazard & !flush;
  assign accept    = in_valid & in_ready;
  assign stall_inc = in_valid & free & hazard & !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (free) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      pc_q      <= '0;
      inst_q    <= ZeroWord;
      reg1_q    <= '0;
      reg2_q    <= '0;
      imm_q     <= '0;
      waddr_q   <= 5'd0;
      we_q      <= WriteDisable;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      // accept is already false during flush, so flushed data is never loaded
      if (accept) begin
        pc_q      <= in_pc;
        inst_q    <= in_inst;
        reg1_q    <= op1;
        reg2_q    <= op2;
        imm_q     <= imm_ext;
        waddr_q   <= dec.waddr;
        we_q      <= dec.we;
        illegal_q <= dec.illegal;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;
  assign out_reg1    = reg1_q;
  assign out_reg2    = reg2_q;
  assign out_imm     = imm_q;
  assign out_waddr   = waddr_q;
  assign out_we      = we_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_pipe
// Directed bench for id_pipe. The driver pushes the hand-computed expected
// output of each accepted instruction into exp_q; an independent monitor pops
// and compares on every output transfer. Handshake, hazard, flush, counter
// and reset behaviour are checked directly against constants.
// -----------------------------------------------------------------------------
module tb_id_pipe;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic        we;
    logic        ill;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [31:0]             in_inst;
  logic                    flush;
  logic [4:0]              reg1_raddr;
  logic [4:0]              reg2_raddr;
  logic [XLEN-1:0]         reg1_rdata;
  logic [XLEN-1:0]         reg2_rdata;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_FWD-1:0]      fwd_ld;
  logic [NUM_FWD*5-1:0]    fwd_waddr;
  logic [NUM_FWD*XLEN-1:0] fwd_wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_inst;
  logic [XLEN-1:0]         out_reg1;
  logic [XLEN-1:0]         out_reg2;
  logic [XLEN-1:0]         out_imm;
  logic [4:0]              out_waddr;
  logic                    out_we;
  logic                    out_illegal;
  logic [CNT_W-1:0]        stall_cnt;

  logic [W-1:0] exp_q[$];
  exp_t         mon_e;
  exp_t         mon_a;
  int           errors = 0;
  int           checks = 0;

  id_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .flush       (flush),
    .reg1_raddr  (reg1_raddr),
    .reg2_raddr  (reg2_raddr),
    .reg1_rdata  (reg1_rdata),
    .reg2_rdata  (reg2_rdata),
    .fwd_we      (fwd_we),
    .fwd_ld      (fwd_ld),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_reg1    (out_reg1),
    .out_reg2    (out_reg2),
    .out_imm     (out_imm),
    .out_waddr   (out_waddr),
    .out_we      (out_we),
    .out_illegal (out_illegal),
    .stall_cnt   (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // driver: called just after a falling edge, returns just after a falling edge
  task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                      input logic [4:0] wa, input logic we, input logic ill, input bit push);
    int budget;
    in_pc    = pc;
    in_inst  = inst;
    in_valid = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=0x%08h: in_ready stayed 0, expected 1", pc);
    end else if (push) begin
      exp_q.push_back({pc, inst, r1, r2, imm, wa, we, ill});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // scoreboard monitor: compare every output transfer
  always begin
    @(negedge clk);
    #2;
    if (rst && out_valid && out_ready) begin
      checks++;
      mon_a = {out_pc, out_inst, out_reg1, out_reg2, out_imm, out_waddr, out_we, out_illegal};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc=0x%08h inst=0x%08h, expected no output", out_pc, out_inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL out_pc_%08h: got inst=%h r1=%h r2=%h imm=%h wa=%0d we=%b ill=%b, expected inst=%h r1=%h r2=%h imm=%h wa=%0d we=%b ill=%b",
                   mon_e.pc, mon_a.inst, mon_a.r1, mon_a.r2, mon_a.imm, mon_a.waddr, mon_a.we, mon_a.ill,
                   mon_e.inst, mon_e.r1, mon_e.r2, mon_e.imm, mon_e.waddr, mon_e.we, mon_e.ill);
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_pc      = '0;
    in_inst    = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    fwd_we     = '0;
    fwd_ld     = '0;
    fwd_waddr  = '0;
    fwd_wdata  = '0;
    reg1_rdata = 32'hA1;
    reg2_rdata = 32'hB2;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready",    32'(in_ready), 32'd0);
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_stall_cnt",   32'(stall_cnt), 32'd0);
    check("rst_out_we",      32'(out_we), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_out_pc",      out_pc, 32'd0);
    check("rst_out_reg1",    out_reg1, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // read addresses are combinational from in_inst
    in_inst = 32'h002081B3;
    #1;
    check("raddr1", 32'(reg1_raddr), 32'd1);
    check("raddr2", 32'(reg2_raddr), 32'd2);
    @(negedge clk);

    // ADDI x5,x0,-1
    send(32'h100, 32'hFFF00293, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b1);

    // ADD x3,x1,x2: both sources write x1, index 0 wins; x2 from regfile
    fwd_we     = 2'b11;
    fwd_waddr  = {5'd1, 5'd1};
    fwd_wdata  = {32'h22, 32'h11};
    reg2_rdata = 32'h7;
    send(32'h104, 32'h002081B3, 32'h11, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
    fwd_we     = 2'b00;
    reg2_rdata = 32'hB2;

    // immediate formats and funct7 legality, back to back
    send(32'h108, 32'h123450B7, 32'h0,  32'h0,  32'h12345000, 5'd1, 1'b1, 1'b0, 1'b1); // LUI
    send(32'h10C, 32'hFFDFF0EF, 32'h0,  32'h0,  32'hFFFFFFFC, 5'd1, 1'b1, 1'b0, 1'b1); // JAL -4
    send(32'h110, 32'h00208863, 32'hA1, 32'hB2, 32'h10,       5'd0, 1'b0, 1'b0, 1'b1); // BEQ +16
    send(32'h114, 32'h4030D093, 32'hA1, 32'h0,  32'h3,        5'd1, 1'b1, 1'b0, 1'b1); // SRAI 3
    send(32'h118, 32'h2030D093, 32'h0,  32'h0,  32'h0,        5'd0, 1'b0, 1'b1, 1'b1); // bad funct7
    send(32'h11C, 32'hFFFFFFFF, 32'h0,  32'h0,  32'h0,        5'd0, 1'b0, 1'b1, 1'b1); // bad opcode

    // forward (even a pending load) to x0 never applies and never stalls
    fwd_we    = 2'b01;
    fwd_ld    = 2'b01;
    fwd_waddr = {5'd0, 5'd0};
    fwd_wdata = {32'h0, 32'hEE};
    send(32'h120, 32'h000003B3, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    check("x0_no_stall", 32'(stall_cnt), 32'd0);
    fwd_we = 2'b00;
    fwd_ld = 2'b00;

    // MUL x0,x1,x2
`ifdef ID_PIPE_RVM_EN
    send(32'h124, 32'h02208033, 32'hA1, 32'hB2, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1);
`else
    send(32'h124, 32'h02208033, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1);
`endif

    // load-use: source 0 is a pending load of x4, SW x4,8(x2) stalls 2 cycles
    fwd_we    = 2'b01;
    fwd_ld    = 2'b01;
    fwd_waddr = {5'd0, 5'd4};
    fwd_wdata = {32'h0, 32'h0};
    in_pc     = 32'h128;
    in_inst   = 32'h00412423;
    in_valid  = 1'b1;
    #1;
    check("hazard_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("hazard_in_ready2", 32'(in_ready), 32'd0);
    check("hazard_stall_cnt", 32'(stall_cnt), 32'd2);
    fwd_ld    = 2'b00;
    fwd_wdata = {32'h0, 32'hAB};
    send(32'h128, 32'h00412423, 32'hA1, 32'hAB, 32'h8, 5'd0, 1'b0, 1'b0, 1'b1);
    check("hazard_cleared_cnt", 32'(stall_cnt), 32'd2);
    fwd_we = 2'b00;
    @(negedge clk);

    // hold: out_ready low keeps the output stable and not re-resolved
    out_ready  = 1'b0;
    reg1_rdata = 32'h1234;
    send(32'h200, 32'h00508313, 32'h1234, 32'h0, 32'h5, 5'd6, 1'b1, 1'b0, 1'b0);
    reg1_rdata = 32'h9999;
    in_pc      = 32'h300;
    in_inst    = 32'h00100093;
    in_valid   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_pc",       out_pc, 32'h200);
      check("hold_reg1",     out_reg1, 32'h1234);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    reg1_rdata = 32'hA1;
    @(negedge clk);
    #1;
    check("flush_drop", 32'(out_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // hazard together with flush does not count
    fwd_we    = 2'b01;
    fwd_ld    = 2'b01;
    fwd_waddr = {5'd0, 5'd4};
    in_pc     = 32'h400;
    in_inst   = 32'h00412423;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    #1;
    check("flush_hazard_cnt", 32'(stall_cnt), 32'd2);
    flush = 1'b0;

    // saturation: climb to 0xFFFE, then 3 more stall cycles stop at 0xFFFF
    repeat (16'hFFFE - 2) @(negedge clk);
    #1;
    check("cnt_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) @(negedge clk);
    #1;
    check("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    check("sat_in_ready", 32'(in_ready), 32'd0);

    // reset mid-stall clears everything
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_valid",    32'(out_valid), 32'd0);
    check("mid_rst_pc",       out_pc, 32'd0);
    check("mid_rst_inst",     out_inst, 32'd0);
    check("mid_rst_reg1",     out_reg1, 32'd0);
    check("mid_rst_imm",      out_imm, 32'd0);
    check("mid_rst_waddr",    32'(out_waddr), 32'd0);
    check("mid_rst_we",       32'(out_we), 32'd0);
    check("mid_rst_cnt",      32'(stall_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides. It sits between the fetch/IF-ID register and the execute stage. It decodes opcode, funct3 and funct7 into operand-enable, immediate and write-back controls, and resolves operands from the regfile or from `NUM_FWD` prioritised forwarding sources. It interlocks on load-use hazards, supports a pipeline flush, and keeps a saturating stall-cycle counter.

## Interface
- `XLEN`, 32: data and PC width.
- `NUM_FWD`, 2: number of forwarding sources. Index 0 is the youngest and has the highest priority.
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Synchronous and active-low: reset is applied at the rising edge while `rst`==0, so `RstEnable` is 1'b0.
- `in_valid` in 1, `in_ready` out 1: instruction handshake from fetch.
- `in_pc` in XLEN, `in_inst` in 32: instruction address and word.
- `flush` in 1: redirect from execute; kills the held and the incoming instruction.
- `reg1_raddr` out 5, `reg2_raddr` out 5: regfile read addresses; combinational, driven from `in_inst`.
- `reg1_rdata` in XLEN, `reg2_rdata` in XLEN: regfile read data, same cycle.
- `fwd_we` in NUM_FWD: per-source write enable.
- `fwd_ld` in NUM_FWD: per-source flag; the source is a load whose data is not yet valid.
- `fwd_waddr` in NUM_FWD*5, `fwd_wdata` in NUM_FWD*XLEN: packed per-source destination address and data; source i occupies slice i.
- `out_valid` out 1, `out_ready` in 1: handshake to execute.
- `out_pc` out XLEN, `out_inst` out 32: registered copies of the accepted PC and instruction.
- `out_reg1` out XLEN, `out_reg2` out XLEN: resolved operands.
- `out_imm` out XLEN: sign-extended immediate.
- `out_waddr` out 5, `out_we` out 1: destination register and write enable.
- `out_illegal` out 1: the instruction was not recognised.
- `stall_cnt` out CNT_W: count of hazard-stall cycles.

## Operation
- Decode, per opcode and funct3:
  - OP_R: rs1, rs2, rd.
  - OP_I: rs1, rd; I-immediate. Shifts take shamt zero-extended; for SRLI/SRAI, funct7 must be 0x00 or 0x20.
  - OP_L: rs1, rd; I-immediate.
  - OP_S: rs1, rs2; S-immediate.
  - OP_B: rs1, rs2; B-immediate.
  - LUI and AUIPC: rd; U-immediate.
  - JAL: rd; J-immediate.
  - JALR: rs1, rd; I-immediate.
  - Any other encoding, or an invalid funct3/funct7: `out_illegal`=1, with all enables and `out_imm` at zero.
- Operand resolution, per operand:
  - Disabled operand: 0.
  - rs==x0: 0, never forwarded.
  - Otherwise, the lowest index i with `fwd_we[i]` set and `fwd_waddr[i]`==rs supplies `fwd_wdata[i]`.
  - If no source matches, the regfile data is used.
- Load-use hazard: an enabled rs≠0 matches some source i with `fwd_we[i]`&`fwd_ld[i]`, and no lower index also matches rs.
- Handshake:
  - Output register free = !`out_valid` | `out_ready`.
  - `in_ready` = free & !hazard & !`flush`.
  - Accept = `in_valid` & `in_ready`. On accept, all `out_*` load next edge and `out_valid`=1.
  - If the register is free and there is no accept, `out_valid`=0 next edge.
  - If `out_valid` & !`out_ready`, all outputs hold stable.
- Flush has top priority: `out_valid`=0 next edge and no accept that cycle. The data registers may keep stale values.
- `stall_cnt` increments on each cycle with `in_valid` & free & hazard & !`flush`. It saturates at all-ones and never wraps.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when there is no hazard and `out_ready`=1.
- Operands are sampled in the accept cycle. A held output is not re-resolved.
- Reset: `out_valid`=0, all `out_*` data=0, `out_we`=0, `out_illegal`=0, `stall_cnt`=0.
- During reset, `in_ready`=0. A reset applied mid-stall or mid-hold drops the instruction.
- `reg*_raddr` are combinational from `in_inst`, with no extra latency.
- If a hazard and a flush occur in the same cycle, the counter does not increment.

## Configuration
- `ID_PIPE_RVM_EN`: when defined, OP_R with funct7=0000001 decodes as RV32M: rs1, rs2, rd, legal for all funct3.
- Without it, that encoding raises `out_illegal`=1 with all enables at zero.

## Structure
- A shared package holds:
  - Opcode constants: OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR.
  - The FUNC3_* and funct7 constants.
  - `RstEnable`=1'b0, the read/write enables, and `ZeroWord`.
- One sub-module, `id_decode`: purely combinational inst→{enables, imm, waddr, illegal}.
- `id_pipe` holds forwarding, hazard detection, the handshake register and the counter.

## Test plan
- ADDI x5,x0,-1 (0xFFF00293), `out_ready`=1 → next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_waddr`=5, `out_we`=1, `out_reg1`=0.
- ADD x3,x1,x2 with source0 writing x1=0x11 and source1 writing x1=0x22, x2 from regfile=0x7 → `out_reg1`=0x11, `out_reg2`=0x7.
- Source0: `fwd_we`=1, `fwd_ld`=1, x4. Send SW x4,8(x2) → `in_ready`=0 for 2 stalled cycles, `stall_cnt`=2. Clear `fwd_ld` with data 0xAB → accepted, `out_reg2`=0xAB, `out_imm`=8.
- `out_ready`=0 with a valid instruction held for 5 cycles → outputs stable and `in_ready`=0. Assert `flush` → `out_valid`=0 next cycle.
- Instruction word 0x02208033 (MUL x0,x1,x2) → `out_illegal`=1 without `ID_PIPE_RVM_EN`; `out_illegal`=0 with reg1/reg2 enabled when it is defined. Any forward to x0 → operand reads 0.
- Preload `stall_cnt`=0xFFFE and hold the hazard 3 cycles → counter reads 0xFFFF. Pull `rst`=0 mid-stall → all outputs are 0 next edge.
